// File: rtl/duck_round_ctl.sv
//------------------------------------------------------------------------------
// duck_round_ctl : round sequencer for the duck-hunt game stage
//                  (intro, timed hunt rounds, pauses, scoring, game over)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module duck_round_ctl #(
  parameter int INTRO_CYCLES = 2_000_000,
  parameter int ROUND_CYCLES = 6_500_000,
  parameter int PAUSE_CYCLES = 1_000_000,
  parameter int MAX_ROUNDS   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic       duck_killed,
  input  logic       bullets_empty,
  output logic       hunt_start,
  output logic       duck_escaped,
  output logic [6:0] enemy_score,
  output logic [6:0] hits,
  output logic [6:0] round_num,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTRO = 3'd1,
    S_HUNT  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [22:0] INTRO_LAST = 23'(INTRO_CYCLES - 1);
  localparam logic [22:0] ROUND_LAST = 23'(ROUND_CYCLES - 1);
  localparam logic [22:0] PAUSE_LAST = 23'(PAUSE_CYCLES - 1);
  localparam logic [22:0] TIMER_MAX  = '1;
  localparam logic [6:0]  ROUND_MAX  = 7'(MAX_ROUNDS);
  localparam logic [6:0]  SCORE_MAX  = 7'd99;

  state_t      state_q, state_d;
  logic [22:0] timer_q, timer_d;
  logic [6:0]  score_q, score_d;
  logic [6:0]  hits_q, hits_d;
  logic [6:0]  round_q, round_d;
  logic        hunt_q, hunt_d;
  logic        esc_q, esc_d;
  logic        over_q, over_d;

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 23'd1;
    score_d = score_q;
    hits_d  = hits_q;
    round_d = round_q;
    esc_d   = 1'b0;

    // Dropping game_enable abandons everything but keeps the scores visible.
    if (!game_enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_INTRO;
          score_d = '0;
          hits_d  = '0;
          round_d = '0;
        end
        S_INTRO: begin
          if (timer_q == INTRO_LAST) begin
            state_d = S_HUNT;
            round_d = (round_q < ROUND_MAX) ? round_q + 7'd1 : round_q;
          end
        end
        S_HUNT: begin
          // A kill wins over a same-cycle escape condition.
          if (duck_killed) begin
            state_d = S_PAUSE;
            hits_d  = (hits_q < SCORE_MAX) ? hits_q + 7'd1 : hits_q;
          end else if (bullets_empty || timer_q == ROUND_LAST) begin
            state_d = S_PAUSE;
            esc_d   = 1'b1;
            score_d = (score_q < SCORE_MAX) ? score_q + 7'd1 : score_q;
          end
        end
        S_PAUSE: begin
          if (timer_q == PAUSE_LAST) begin
            if (round_q >= ROUND_MAX || bullets_empty) begin
              state_d = S_DONE;
            end else begin
              state_d = S_HUNT;
              round_d = round_q + 7'd1;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q || state_d == S_IDLE || state_d == S_DONE) begin
      timer_d = '0;
    end

    hunt_d = (state_d == S_HUNT);
    over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      score_q <= '0;
      hits_q  <= '0;
      round_q <= '0;
      hunt_q  <= 1'b0;
      esc_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      score_q <= score_d;
      hits_q  <= hits_d;
      round_q <= round_d;
      hunt_q  <= hunt_d;
      esc_q   <= esc_d;
      over_q  <= over_d;
    end
  end

  assign hunt_start   = hunt_q;
  assign duck_escaped = esc_q;
  assign enemy_score  = score_q;
  assign hits         = hits_q;
  assign round_num    = round_q;
  assign game_over    = over_q;

endmodule

`default_nettype wire

// File: tb/tb_duck_round_ctl.sv
//------------------------------------------------------------------------------
// tb_duck_round_ctl : scoreboard bench for duck_round_ctl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_duck_round_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_enable = 1'b0;
  logic       duck_killed = 1'b0;
  logic       bullets_empty = 1'b0;
  logic       hunt_start;
  logic       duck_escaped;
  logic [6:0] enemy_score;
  logic [6:0] hits;
  logic [6:0] round_num;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] hits;
    logic [6:0] score;
    logic [6:0] rnd;
    logic       esc;
  } exp_t;

  exp_t sb[$];

  duck_round_ctl #(
    .INTRO_CYCLES(4),
    .ROUND_CYCLES(8),
    .PAUSE_CYCLES(3),
    .MAX_ROUNDS  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_enable  (game_enable),
    .duck_killed  (duck_killed),
    .bullets_empty(bullets_empty),
    .hunt_start   (hunt_start),
    .duck_escaped (duck_escaped),
    .enemy_score  (enemy_score),
    .hits         (hits),
    .round_num    (round_num),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] h, input logic [6:0] s,
                          input logic [6:0] r, input logic e);
    exp_t x;
    x.hits = h; x.score = s; x.rnd = r; x.esc = e;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1; game_enable = 1'b1; duck_killed = 1'b1; bullets_empty = 1'b1;
    step(); step();
    total++;
    if ({hunt_start, duck_escaped, game_over, enemy_score, hits, round_num} !== 24'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {hunt_start, duck_escaped, game_over, enemy_score, hits, round_num});
    end
    rst = 1'b0; game_enable = 1'b0; duck_killed = 1'b0; bullets_empty = 1'b0;
    step();
  endtask

  task automatic test_normal_kill();
    int n;
    exp_t x;
    game_enable = 1'b1;
    n = 0;
    while (hunt_start !== 1'b1 && n < 20) begin
      step(); n++;
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL intro_latency got=%0d exp=5", n); end
    total++;
    if (round_num !== 7'd1) begin bad++; $display("FAIL round1 got=%0d exp=1", round_num); end
    step(); step();
    duck_killed = 1'b1;
    push_exp(7'd1, 7'd0, 7'd1, 1'b0);
    step();
    duck_killed = 1'b0;
    x = sb.pop_front();
    total++;
    if (hits !== x.hits || enemy_score !== x.score || round_num !== x.rnd || duck_escaped !== x.esc) begin
      bad++;
      $display("FAIL kill_outcome got=h%0d s%0d r%0d e%0b exp=h%0d s%0d r%0d e%0b",
               hits, enemy_score, round_num, duck_escaped, x.hits, x.score, x.rnd, x.esc);
    end
    total++;
    if (hunt_start !== 1'b0) begin bad++; $display("FAIL kill_hunt_drop got=%b exp=0", hunt_start); end
    duck_killed = 1'b1;
    n = 0;
    while (hunt_start !== 1'b1 && n < 20) begin
      step(); n++; duck_killed = 1'b0;
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL pause_len got=%0d exp=3", n); end
    total++;
    if (round_num !== 7'd2 || hits !== 7'd1) begin
      bad++; $display("FAIL round2 got=r%0d h%0d exp=r2 h1", round_num, hits);
    end
  endtask

  task automatic test_timeout();
    int n;
    int escs;
    exp_t x;
    push_exp(7'd1, 7'd1, 7'd2, 1'b1);
    n = 0;
    while (duck_escaped !== 1'b1 && n < 20) begin
      step(); n++;
    end
    total++;
    if (n != 8) begin bad++; $display("FAIL timeout_len got=%0d exp=8", n); end
    x = sb.pop_front();
    total++;
    if (hits !== x.hits || enemy_score !== x.score || round_num !== x.rnd || duck_escaped !== x.esc) begin
      bad++;
      $display("FAIL timeout_outcome got=h%0d s%0d r%0d e%0b exp=h%0d s%0d r%0d e%0b",
               hits, enemy_score, round_num, duck_escaped, x.hits, x.score, x.rnd, x.esc);
    end
    escs = 0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (hunt_start !== 1'b0) begin bad++; $display("FAIL pause_hunt_low got=%b exp=0", hunt_start); end
      step();
      if (duck_escaped === 1'b1) escs++;
    end
    total++;
    if (escs != 0) begin bad++; $display("FAIL escape_width got=%0d extra exp=0", escs); end
  endtask

  task automatic test_game_end();
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (game_over !== 1'b1 || hunt_start !== 1'b0) begin
        bad++; $display("FAIL done_hold got=go%b hs%b exp=go1 hs0", game_over, hunt_start);
      end
      step();
    end
    game_enable = 1'b0;
    step();
    total++;
    if (game_over !== 1'b0 || hits !== 7'd1 || enemy_score !== 7'd1 || round_num !== 7'd2) begin
      bad++;
      $display("FAIL idle_scores_held got=go%b h%0d s%0d r%0d exp=go0 h1 s1 r2",
               game_over, hits, enemy_score, round_num);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    exp_t x;
    game_enable = 1'b1;
    step();
    step();
    total++;
    if (hits !== 7'd0 || enemy_score !== 7'd0 || round_num !== 7'd0) begin
      bad++; $display("FAIL clear_on_start got=h%0d s%0d r%0d exp=0 0 0", hits, enemy_score, round_num);
    end
    duck_killed = 1'b1;
    step();
    duck_killed = 1'b0;
    n = 0;
    while (hunt_start !== 1'b1 && n < 20) begin
      step(); n++;
    end
    total++;
    if (hits !== 7'd0) begin bad++; $display("FAIL kill_outside_hunt got=%0d exp=0", hits); end
    duck_killed = 1'b1; bullets_empty = 1'b1;
    push_exp(7'd1, 7'd0, 7'd1, 1'b0);
    step();
    duck_killed = 1'b0; bullets_empty = 1'b0;
    x = sb.pop_front();
    total++;
    if (hits !== x.hits || enemy_score !== x.score || round_num !== x.rnd || duck_escaped !== x.esc) begin
      bad++;
      $display("FAIL simul_outcome got=h%0d s%0d r%0d e%0b exp=h%0d s%0d r%0d e%0b",
               hits, enemy_score, round_num, duck_escaped, x.hits, x.score, x.rnd, x.esc);
    end
  endtask

  task automatic test_bullets_empty();
    int n;
    exp_t x;
    n = 0;
    while (hunt_start !== 1'b1 && n < 20) begin
      step(); n++;
    end
    total++;
    if (round_num !== 7'd2) begin bad++; $display("FAIL be_round got=%0d exp=2", round_num); end
    step();
    bullets_empty = 1'b1;
    push_exp(7'd1, 7'd1, 7'd2, 1'b1);
    step();
    x = sb.pop_front();
    total++;
    if (hits !== x.hits || enemy_score !== x.score || round_num !== x.rnd || duck_escaped !== x.esc) begin
      bad++;
      $display("FAIL empty_outcome got=h%0d s%0d r%0d e%0b exp=h%0d s%0d r%0d e%0b",
               hits, enemy_score, round_num, duck_escaped, x.hits, x.score, x.rnd, x.esc);
    end
    step(); step(); step();
    total++;
    if (game_over !== 1'b1 || enemy_score !== 7'd1) begin
      bad++; $display("FAIL empty_done got=go%b s%0d exp=go1 s1", game_over, enemy_score);
    end
    bullets_empty = 1'b0;
    game_enable = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_hunt();
    int n;
    int escs;
    game_enable = 1'b1;
    n = 0;
    while (hunt_start !== 1'b1 && n < 20) begin
      step(); n++;
    end
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({hunt_start, duck_escaped, game_over, enemy_score, hits, round_num} !== 24'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {hunt_start, duck_escaped, game_over, enemy_score, hits, round_num});
    end
    n = 0; escs = 0;
    while (hunt_start !== 1'b1 && n < 20) begin
      step(); n++;
      if (duck_escaped === 1'b1) escs++;
    end
    total++;
    if (n != 5 || escs != 0 || round_num !== 7'd1) begin
      bad++; $display("FAIL midreset_restart got=n%0d esc%0d r%0d exp=n5 esc0 r1", n, escs, round_num);
    end
    game_enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_normal_kill();
    test_timeout();
    test_game_end();
    test_simultaneous();
    test_bullets_empty();
    test_reset_mid_hunt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/duck_round_ctl.md
DUCK_ROUND_CTL -- requirements
Module: duck_round_ctl

Parameters
REQ-001 The block SHALL have parameter INTRO_CYCLES, default 2_000_000, giving the dog-intro length in clk cycles before the first round.
REQ-002 The block SHALL have parameter ROUND_CYCLES, default 6_500_000, giving the per-round duck flight time in clk cycles before escape.
REQ-003 The block SHALL have parameter PAUSE_CYCLES, default 1_000_000, giving the gap in clk cycles between rounds.
REQ-004 The block SHALL have parameter MAX_ROUNDS, default 10, range 1..99, giving the number of rounds per game.

Interface
REQ-005 clk  in  1  system clock; the block SHALL use this single clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 game_enable  in  1  level, high while the game stage is active.
REQ-008 duck_killed  in  1  single-cycle pulse when the duck is hit.
REQ-009 bullets_empty  in  1  level, high when the magazine and reserve are both zero.
REQ-010 hunt_start  out  1  level, high only in HUNT; gates duck motion and shooting.
REQ-011 duck_escaped  out  1  single-cycle pulse on a round lost to timeout or to no ammunition.
REQ-012 enemy_score  out  7  rounds lost, binary, 0..99.
REQ-013 hits  out  7  rounds won, binary, 0..99.
REQ-014 round_num  out  7  current round, 1-based; 0 before the first round.
REQ-015 game_over  out  1  level, high in DONE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, INTRO, HUNT, PAUSE and DONE.
REQ-017 From any state, game_enable=0 SHALL force IDLE on the next cycle. Counters SHALL hold their values so the end screen can still show them.
REQ-018 In IDLE with game_enable=1, the FSM SHALL enter INTRO next cycle. In the same cycle it SHALL clear enemy_score, hits and round_num to 0 and clear the timer.
REQ-019 INTRO SHALL last exactly INTRO_CYCLES cycles. On the exit edge the FSM SHALL enter HUNT, and round_num SHALL increment.
REQ-020 HUNT priority, from highest to lowest:
- duck_killed: hits+1, then PAUSE.
- bullets_empty: duck_escaped pulse and enemy_score+1, then PAUSE.
- timer reaching ROUND_CYCLES-1: duck_escaped pulse and enemy_score+1, then PAUSE.
REQ-021 A kill that arrives in the same cycle as a timeout or bullets_empty SHALL count as a hit only, with no escape pulse.
REQ-022 duck_killed outside HUNT SHALL be ignored.
REQ-023 PAUSE SHALL last exactly PAUSE_CYCLES cycles, then branch:
- round_num == MAX_ROUNDS: go to DONE.
- bullets_empty=1: go to DONE.
- otherwise: go to HUNT, and round_num SHALL increment.
REQ-024 DONE SHALL hold until game_enable=0.
REQ-025 The single 23-bit timer SHALL clear on every state entry, increment each cycle in INTRO, HUNT and PAUSE, and never wrap within a state.
REQ-026 enemy_score and hits SHALL saturate at 99 and round_num SHALL never exceed MAX_ROUNDS.
REQ-027 hunt_start SHALL be a registered output that is high in the same cycles the FSM is in HUNT, with no combinational path from inputs to outputs.
REQ-028 duck_escaped SHALL be exactly 1 cycle wide, and there SHALL be at most one escape per round.

Reset
REQ-029 On rst=1 at a clk edge, the FSM SHALL go to IDLE. This SHALL take priority over all other inputs.
REQ-030 On reset, every output SHALL be 0: hunt_start, duck_escaped, game_over, enemy_score, hits and round_num.
REQ-031 Reset SHALL also clear the timer. Reset asserted mid-round SHALL discard the round with no pulse.

Verification (INTRO=4, ROUND=8, PAUSE=3, MAX_ROUNDS=2)
REQ-032 Normal kill: game_enable rises, then duck_killed arrives at HUNT cycle 3. Required:
- hunt_start rises 5 cycles after game_enable.
- hits=1 and round_num=1.
- hunt_start drops on the next cycle.
- HUNT re-entered after 3 PAUSE cycles with round_num=2.
REQ-033 Timeout: no kill for 8 HUNT cycles. Required: one duck_escaped pulse, enemy_score=1, hunt_start low for the next 3 cycles.
REQ-034 Simultaneous events: duck_killed and bullets_empty in the same HUNT cycle. Required: hits+1, enemy_score unchanged, no escape pulse.
REQ-035 Game end: play both rounds (MAX_ROUNDS=2), then let PAUSE expire. Required: game_over=1 and hunt_start=0 until game_enable=0, then IDLE with the scores held.
REQ-036 Reset mid-HUNT: rst pulsed at HUNT cycle 5. Required: all outputs 0 the next cycle, no duck_escaped pulse, and a fresh INTRO once game_enable is seen high after reset.
